le_cluster: RTL and testbench
=============================

Name: le_cluster

Overview:
- Parametrised successor to the single logic element: a cluster of N logic elements, each with a K-input LUT, on one shared configuration shift chain.
- Adds features the single LE lacks: a ripple carry chain, a synchronous user set/reset, a configuration bit counter with done/error status, and a clean chain tail for daisy-chaining clusters.
- Sits in the fabric tile between the connection boxes (inputs) and the switch boxes (outputs).
- Single clock domain; the user FFs run on clk with per-LE enable.

Parameters:
- N, 4, number of logic elements in the cluster.
- K, 4, LUT inputs per LE; LUT depth is 2**K.
- W (derived), 2**K+3, configuration bits per LE.
- CFG_BITS (derived), N*W, total chain length.

Ports:
- clk  in  1  cluster clock (fabric and configuration).
- rst  in  1  synchronous, active-high reset.
- cfg_en  in  1  shift enable for the configuration chain.
- cfg_in  in  1  serial configuration data in.
- cfg_out  out  1  chain tail, cfg[CFG_BITS-1]; feeds the next cluster.
- cfg_done  out  1  configuration complete and valid.
- cfg_err  out  1  more than CFG_BITS bits were shifted.
- le_en  in  N  per-LE FF clock enable.
- le_srst  in  N  per-LE synchronous user reset; loads reset_val.
- le_in  in  N*K  LUT select inputs; LE i uses le_in[i*K +: K].
- carry_in  in  1  carry into LE0.
- carry_out  out  1  carry out of LE N-1.
- le_out  out  N  LE outputs.

Behaviour:
- Chain: cfg[CFG_BITS-1:0]. On cfg_en: cfg <= {cfg[CFG_BITS-2:0], cfg_in}. rst clears it to 0.
- LE i owns slice cfg[i*W +: W]. Field layout, MSB to LSB: carry_mode | reset_val | reg_mode | lut[2**K-1:0].
- Bit counter cnt (width clog2(CFG_BITS+1)+1):
  - rst clears it.
  - The cycle cfg_en rises (cfg_en high, previous cfg_en low) sets cnt to 1.
  - Each further cfg_en cycle increments cnt; cnt saturates at CFG_BITS+1.
- cfg_err: set when cnt would exceed CFG_BITS. Sticky until rst or the next cfg_en rising edge.
- cfg_done:
  - Set on the first cycle cfg_en is low with cnt==CFG_BITS and cfg_err low.
  - Cleared by rst or any cycle with cfg_en high.
  - A deassertion with cnt<CFG_BITS leaves cfg_done low (partial load).
- LUT mode (carry_mode=0): f_i = lut[le_in_i]. Combinational, zero-cycle path from le_in to le_out.
- Carry mode (carry_mode=1):
  - p = lut[{1'b0, le_in_i[K-2:0]}], g = lut[{1'b1, le_in_i[K-2:0]}].
  - f_i = p ^ c_i, c_{i+1} = p ? c_i : g, with c_0 = carry_in.
  - le_in_i[K-1] is ignored.
  - A non-carry LE passes c_{i+1} = c_i.
  - carry_out = c_N, forced to 0 unless cfg_done.
- User FF q_i, updated on posedge clk, in priority order:
  - rst -> 0
  - else le_srst[i] -> reset_val
  - else le_en[i] -> f_i
  - else hold.
- Output: le_out[i] = (!cfg_done) ? 0 : (reg_mode ? q_i : f_i).
  - Outputs read 0 during configuration, after rst, and after a partial or erroneous load.
- Reset mid-configuration: the chain, cnt, cfg_done, cfg_err and q all clear on the same edge. Shifting resumes from an empty chain.
- Reconfiguring: q keeps its value while cfg_en is high. le_out stays gated to 0 until the new cfg_done.
- Reset values: cfg_out=0, cfg_done=0, cfg_err=0, carry_out=0, le_out=0.

Decomposition:
- Package le_pkg:
  - functions lut_depth(K) and le_cfg_w(K).
  - field offset constants LUT_LSB=0, REG_MODE_OFS=2**K, RST_VAL_OFS=2**K+1, CARRY_OFS=2**K+2.
  - typedef le_cfg_t as a packed struct of the fields, for K=4 benches.
- Sub-module le_slice: one LE, containing the LUT mux, carry cell and FF.
  - Ports: clk, rst, cfg (W), en, srst, sel (K), cin, cout, f/q select, out.
  - le_cluster owns the chain, the counter/status FSM, a generate loop over le_slice, and output gating.

Test Plan (N=4, K=4, W=19, CFG_BITS=76):
- Load 76 bits with all four LEs as comb AND4 (lut=16'h8000, reg_mode=0), then drop cfg_en.
  - cfg_done=1 the next cycle.
  - le_in=16'hFFFF -> le_out=4'hF; le_in=16'hFFFE -> le_out=4'hE.
- Load only 75 bits -> cfg_done=0, le_out=0. Shift 77 bits -> cfg_err=1, cfg_done=0. Assert rst -> both clear.
- Configure a 4-bit adder:
  - Each LE carry_mode=1 with lut p=a^b, g=a&b; operand bits on le_in[1:0].
  - a=4'b1011, b=4'b0110, carry_in=0 -> le_out=4'b0001, carry_out=1.
- Registered mode on LE0 with reset_val=1:
  - le_srst[0] pulse -> q=1 next edge.
  - le_en[0]=0 -> q holds while f changes.
  - le_en[0]=1 -> q follows f with 1-cycle latency.
- Assert rst halfway through a load (cycle 40) -> cfg_out=0, cnt=0. A full 76-bit reload then works and gives cfg_done=1.
- Shift a known 76-bit pattern -> cfg_out replays the first-shifted bit exactly 76 cycles after entry; verifies the daisy chain.

Source files
------------

// File: rtl/le_pkg.sv
// le_pkg: shared sizing helpers, field offsets and types for the logic-element cluster.
// Contents:
//   lut_depth(k), le_cfg_w(k) - LUT depth and per-LE configuration width for k inputs
//   *_OFS / LUT_LSB           - field offsets within one LE slice (K=4 layout)
//   le_cfg_t                  - packed view of one LE slice for K=4
//   cfg_state_t               - configuration status states
package le_pkg;
    function automatic int lut_depth(input int k);
        return 1 << k;
    endfunction
    function automatic int le_cfg_w(input int k);
        return (1 << k) + 3;
    endfunction
    localparam int LE_K         = 4;
    localparam int LUT_LSB      = 0;
    localparam int REG_MODE_OFS = 2**LE_K;
    localparam int RST_VAL_OFS  = 2**LE_K + 1;
    localparam int CARRY_OFS    = 2**LE_K + 2;
    typedef struct packed {
        logic                    carry_mode;
        logic                    reset_val;
        logic                    reg_mode;
        logic [2**LE_K-1:0]      lut;
    } le_cfg_t;
    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE, S_ERR} cfg_state_t;
endpackage

// File: rtl/le_slice.sv
// le_slice: one logic element - K-input LUT, carry cell and user FF.
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   i_cfg      - this LE's configuration slice {carry_mode, reset_val, reg_mode, lut}
//   i_en       - FF enable; i_srst - user reset loading reset_val
//   i_sel      - LUT select inputs
//   i_cin      - carry in; o_cout - carry out (passes i_cin when not in carry mode)
//   o_out      - registered or combinational result, selected by reg_mode
module le_slice
    import le_pkg::*;
#(
    parameter int K = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [le_cfg_w(K)-1:0] i_cfg,
    input  logic                  i_en,
    input  logic                  i_srst,
    input  logic [K-1:0]          i_sel,
    input  logic                  i_cin,
    output logic                  o_cout,
    output logic                  o_out
);
    localparam int D = lut_depth(K);
    logic [D-1:0] w_lut;
    logic         w_carry, w_rst_val, w_reg_mode, w_p, w_g, w_f;
    logic         r_q;
    assign w_lut      = i_cfg[D-1:0];
    assign w_reg_mode = i_cfg[D];
    assign w_rst_val  = i_cfg[D+1];
    assign w_carry    = i_cfg[D+2];
    // Carry mode splits the LUT: lower half is propagate, upper half is generate.
    assign w_p    = w_lut[{1'b0, i_sel[K-2:0]}];
    assign w_g    = w_lut[{1'b1, i_sel[K-2:0]}];
    assign w_f    = w_carry ? (w_p ^ i_cin) : w_lut[i_sel];
    assign o_cout = w_carry ? (w_p ? i_cin : w_g) : i_cin;
    assign o_out  = w_reg_mode ? r_q : w_f;
    always_ff @(posedge clk) begin
        if (rst)
            r_q <= 1'b0;
        else if (i_srst)
            r_q <= w_rst_val;
        else if (i_en)
            r_q <= w_f;
    end
endmodule

// File: rtl/le_cluster.sv
// le_cluster: N logic elements on one serial configuration chain with carry chain and load status.
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   i_cfg_en, i_cfg_in       - configuration shift enable and serial data
//   o_cfg_out                - chain tail for daisy-chaining the next cluster
//   o_cfg_done, o_cfg_err    - exact-length load complete / overlong load
//   i_le_en, i_le_srst       - per-LE FF enable and user reset
//   i_le_in                  - LUT selects, LE i uses i_le_in[i*K +: K]
//   i_carry_in, o_carry_out  - ripple carry chain ends
//   o_le_out                 - LE outputs, forced to 0 until a valid load
module le_cluster
    import le_pkg::*;
#(
    parameter int N = 4,
    parameter int K = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           i_cfg_en,
    input  logic           i_cfg_in,
    output logic           o_cfg_out,
    output logic           o_cfg_done,
    output logic           o_cfg_err,
    input  logic [N-1:0]   i_le_en,
    input  logic [N-1:0]   i_le_srst,
    input  logic [N*K-1:0] i_le_in,
    input  logic           i_carry_in,
    output logic           o_carry_out,
    output logic [N-1:0]   o_le_out
);
    localparam int W        = le_cfg_w(K);
    localparam int CFG_BITS = N * W;
    localparam int CW       = $clog2(CFG_BITS + 1) + 1;
    localparam logic [CW-1:0] FULL = CW'(CFG_BITS);
    localparam logic [CW-1:0] SAT  = CW'(CFG_BITS + 1);
    logic [CFG_BITS-1:0] r_cfg;
    logic [CW-1:0]       r_cnt, w_cnt_nxt;
    cfg_state_t          r_state, w_state_nxt;
    logic                r_cfg_en_d, w_rise;
    logic [N:0]          w_c;
    logic [N-1:0]        w_out;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cfg      <= '0;
            r_cnt      <= '0;
            r_state    <= S_IDLE;
            r_cfg_en_d <= 1'b0;
        end else begin
            r_cnt      <= w_cnt_nxt;
            r_state    <= w_state_nxt;
            r_cfg_en_d <= i_cfg_en;
            if (i_cfg_en)
                r_cfg <= {r_cfg[CFG_BITS-2:0], i_cfg_in};
        end
    end
    // A shift beyond the full length is an error; a rising edge starts a fresh load.
    always_comb begin
        w_rise      = i_cfg_en && !r_cfg_en_d;
        w_cnt_nxt   = w_rise ? CW'(1) : (i_cfg_en && r_cnt != SAT) ? r_cnt + CW'(1) : r_cnt;
        w_state_nxt = r_state;
        if (i_cfg_en)
            w_state_nxt = (!w_rise && r_cnt >= FULL) ? S_ERR : S_SHIFT;
        else if (r_state == S_SHIFT)
            w_state_nxt = (r_cnt == FULL) ? S_DONE : S_IDLE;
    end
    assign w_c[0] = i_carry_in;
    for (genvar g = 0; g < N; g++) begin : g_le
        le_slice #(.K(K)) u_le (
            .clk    (clk),
            .rst    (rst),
            .i_cfg  (r_cfg[g*W +: W]),
            .i_en   (i_le_en[g]),
            .i_srst (i_le_srst[g]),
            .i_sel  (i_le_in[g*K +: K]),
            .i_cin  (w_c[g]),
            .o_cout (w_c[g+1]),
            .o_out  (w_out[g])
        );
    end
    assign o_cfg_out   = r_cfg[CFG_BITS-1];
    assign o_cfg_done  = (r_state == S_DONE);
    assign o_cfg_err   = (r_state == S_ERR);
    assign o_carry_out = o_cfg_done & w_c[N];
    assign o_le_out    = o_cfg_done ? w_out : '0;
endmodule

// File: tb/tb_le_cluster.sv
// tb_le_cluster: directed, table-driven checks of le_cluster (N=4, K=4, 76-bit chain).
module tb_le_cluster;
    import le_pkg::*;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        i_cfg_en = 1'b0, i_cfg_in = 1'b0;
    logic        o_cfg_out, o_cfg_done, o_cfg_err;
    logic [3:0]  i_le_en = '0, i_le_srst = '0;
    logic [15:0] i_le_in = '0;
    logic        i_carry_in = 1'b0, o_carry_out;
    logic [3:0]  o_le_out;
    int n_tests = 0, n_fail = 0;

    le_cluster #(.N(4), .K(4)) dut (
        .clk(clk), .rst(rst), .i_cfg_en(i_cfg_en), .i_cfg_in(i_cfg_in),
        .o_cfg_out(o_cfg_out), .o_cfg_done(o_cfg_done), .o_cfg_err(o_cfg_err),
        .i_le_en(i_le_en), .i_le_srst(i_le_srst), .i_le_in(i_le_in),
        .i_carry_in(i_carry_in), .o_carry_out(o_carry_out), .o_le_out(o_le_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        mode;
        logic [15:0] le_in;
        logic        cin;
        logic [3:0]  exp_out;
        logic        exp_cout;
    } vec_t;

    le_cfg_t c_and = '{carry_mode: 1'b0, reset_val: 1'b0, reg_mode: 1'b0, lut: 16'h8000};
    le_cfg_t c_add = '{carry_mode: 1'b1, reset_val: 1'b0, reg_mode: 1'b0, lut: 16'h0806};
    le_cfg_t c_reg = '{carry_mode: 1'b0, reset_val: 1'b1, reg_mode: 1'b1, lut: 16'h8000};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        i_cfg_en = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic shift_bits(input logic [75:0] v, input int n);
        for (int i = 0; i < n; i++) begin
            i_cfg_en = 1'b1;
            i_cfg_in = (i < 76) ? v[75-i] : 1'b0;
            tick();
        end
        i_cfg_en = 1'b0;
        i_cfg_in = 1'b0;
    endtask

    task automatic load(input logic [75:0] v);
        shift_bits(v, 76);
        tick();
    endtask

    function automatic logic [15:0] mk(input logic [3:0] a, input logic [3:0] b);
        logic [15:0] r = '0;
        for (int i = 0; i < 4; i++) r[i*4 +: 4] = {2'b00, b[i], a[i]};
        return r;
    endfunction

    initial begin
        vec_t        tbl[13];
        int          cur;
        logic [75:0] pat;
        tbl[0]  = '{1'b0, 16'hFFFF, 1'b0, 4'hF, 1'b0};
        tbl[1]  = '{1'b0, 16'hFFFE, 1'b1, 4'hE, 1'b1};
        tbl[2]  = '{1'b0, 16'h0000, 1'b1, 4'h0, 1'b1};
        tbl[3]  = '{1'b0, 16'h7FFF, 1'b0, 4'h7, 1'b0};
        tbl[4]  = '{1'b0, 16'hF0FF, 1'b0, 4'hB, 1'b0};
        tbl[5]  = '{1'b1, mk(4'hB, 4'h6), 1'b0, 4'h1, 1'b1};
        tbl[6]  = '{1'b1, mk(4'h0, 4'h0), 1'b0, 4'h0, 1'b0};
        tbl[7]  = '{1'b1, mk(4'hF, 4'h1), 1'b0, 4'h0, 1'b1};
        tbl[8]  = '{1'b1, mk(4'h5, 4'h3), 1'b1, 4'h9, 1'b0};
        tbl[9]  = '{1'b1, mk(4'h7, 4'h8), 1'b1, 4'h0, 1'b1};
        tbl[10] = '{1'b1, mk(4'h2, 4'h3), 1'b0, 4'h5, 1'b0};
        tbl[11] = '{1'b1, mk(4'hB, 4'h6) | 16'h8888, 1'b0, 4'h1, 1'b1};
        tbl[12] = '{1'b1, mk(4'hF, 4'hF), 1'b1, 4'hF, 1'b1};

        pulse_rst();
        i_le_in = 16'hFFFF;
        i_carry_in = 1'b1;
        #1;
        chk("rst_cfg_out", 32'(o_cfg_out), 0);
        chk("rst_done", 32'(o_cfg_done), 0);
        chk("rst_err", 32'(o_cfg_err), 0);
        chk("rst_cout", 32'(o_carry_out), 0);
        chk("rst_le_out", 32'(o_le_out), 0);

        shift_bits({c_and, c_and, c_and, c_and}, 76);
        chk("done_before_drop_edge", 32'(o_cfg_done), 0);
        tick();
        chk("done_after_load", 32'(o_cfg_done), 1);

        cur = 0;
        for (int i = 0; i < 13; i++) begin
            if (int'(tbl[i].mode) != cur) begin
                load(tbl[i].mode ? {c_add, c_add, c_add, c_add} : {c_and, c_and, c_and, c_and});
                cur = int'(tbl[i].mode);
            end
            i_le_in = tbl[i].le_in;
            i_carry_in = tbl[i].cin;
            #1;
            chk($sformatf("vec%0d_out", i), 32'(o_le_out), 32'(tbl[i].exp_out));
            chk($sformatf("vec%0d_cout", i), 32'(o_carry_out), 32'(tbl[i].exp_cout));
        end

        pulse_rst();
        i_le_in = 16'hFFFF;
        shift_bits({c_and, c_and, c_and, c_and}, 75);
        tick();
        chk("partial_done", 32'(o_cfg_done), 0);
        chk("partial_le_out", 32'(o_le_out), 0);
        shift_bits({c_and, c_and, c_and, c_and}, 77);
        tick();
        chk("over_err", 32'(o_cfg_err), 1);
        chk("over_done", 32'(o_cfg_done), 0);
        chk("over_le_out", 32'(o_le_out), 0);
        i_cfg_en = 1'b1;
        tick();
        chk("err_clear_on_rise", 32'(o_cfg_err), 0);
        i_cfg_en = 1'b0;
        shift_bits({c_and, c_and, c_and, c_and}, 77);
        tick();
        chk("over_err2", 32'(o_cfg_err), 1);
        pulse_rst();
        chk("rst_clears_err", 32'(o_cfg_err), 0);
        chk("rst_clears_done", 32'(o_cfg_done), 0);

        shift_bits({76{1'b1}}, 40);
        pulse_rst();
        chk("midrst_cfg_out", 32'(o_cfg_out), 0);
        shift_bits('0, 36);
        chk("midrst_chain_cleared", 32'(o_cfg_out), 0);
        tick();
        chk("midrst_partial_done", 32'(o_cfg_done), 0);
        load({c_and, c_and, c_and, c_and});
        chk("midrst_reload_done", 32'(o_cfg_done), 1);
        i_le_in = 16'hFFFF;
        #1;
        chk("midrst_reload_out", 32'(o_le_out), 32'hF);

        pulse_rst();
        load({c_and, c_and, c_and, c_reg});
        i_le_in = 16'h0000;
        i_le_en = 4'b0000;
        #1;
        chk("reg_q_init", 32'(o_le_out), 0);
        i_le_srst = 4'b0001;
        tick();
        i_le_srst = 4'b0000;
        chk("reg_srst", 32'(o_le_out), 1);
        tick();
        chk("reg_hold", 32'(o_le_out), 1);
        i_le_en = 4'b0001;
        #1;
        chk("reg_latency", 32'(o_le_out), 1);
        tick();
        chk("reg_follow0", 32'(o_le_out), 0);
        i_le_in = 16'h000F;
        #1;
        chk("reg_latency2", 32'(o_le_out), 0);
        tick();
        chk("reg_follow1", 32'(o_le_out), 1);
        i_le_in = 16'h0000;
        tick();
        chk("reg_follow0b", 32'(o_le_out), 0);
        i_le_srst = 4'b0001;
        tick();
        i_le_srst = 4'b0000;
        i_le_en = 4'b0000;
        chk("reg_srst_priority", 32'(o_le_out), 1);
        i_cfg_en = 1'b1;
        tick();
        chk("reconfig_gated", 32'(o_le_out), 0);
        i_cfg_en = 1'b0;
        pulse_rst();

        pat = 76'hB4D2E1F0C3A5968778A;
        for (int j = 1; j <= 100; j++) begin
            i_cfg_en = 1'b1;
            i_cfg_in = (j <= 76) ? pat[76-j] : 1'b0;
            tick();
            if (j >= 75)
                chk($sformatf("daisy_%0d", j), 32'(o_cfg_out), (j < 76) ? 0 : 32'(pat[75-(j-76)]));
        end
        i_cfg_en = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
